// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor: FSM state encoding
// and the mailbox access qualifiers.
package cpu_run_monitor_pkg;

   typedef enum logic [2:0] {
      HOLD,
      RUN,
      PASS,
      FAIL,
      TMO
   } state_e;

   localparam logic [2:0] MEM_SIZE_WORD  = 3'b010;
   localparam int         CONSOLE_OFFSET = 4;

endpackage

// File: rtl/cpu_run_console_fifo.sv
// 8-bit synchronous console FIFO with a valid/ready read side and a sticky
// overflow flag. Pointers carry one extra bit to tell full from empty.
module cpu_run_console_fifo #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       overflow_o
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [7:0]          mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d;
   logic                ovf_q, ovf_d;
   logic                empty, full, pop, do_push;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                    (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
   assign pop     = !empty && ready_i;
   // A pop on the same edge frees the slot the push needs.
   assign do_push = push_i && (!full || pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      ovf_d = ovf_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (pop) rd_d = rd_q + 1'b1;
      if (push_i && !do_push) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= data_i;
   end

   assign valid_o    = !empty;
   assign data_o     = empty ? 8'h00 : mem_q[rd_q[DEPTH_LOG2-1:0]];
   assign overflow_o = ovf_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller: sequences CPU reset, counts RUN cycles, latches a pass/fail/
// timeout verdict from tohost stores. Console FIFO under CPU_RUN_MONITOR_CONSOLE_EN.
module cpu_run_monitor
   import cpu_run_monitor_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                CNT_W          = 32,
   parameter int                RST_CYCLES     = 4,
   parameter int                TIMEOUT        = 100000,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter int                CON_DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [2:0]        mem_size,
   output logic              cpu_reset,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              done,
   output logic              pass,
   output logic              timed_out,
   output logic [DATA_W-1:0] fail_code,
   output logic [7:0]        con_data,
   output logic              con_valid,
   input  logic              con_ready,
   output logic              con_overflow
);

   localparam int RW = $clog2(RST_CYCLES + 1);

   state_e            state_q, state_d;
   logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] fc_q, fc_d;
   logic              word_wr, hit, con_hit;

   assign word_wr = mem_we && (mem_size == MEM_SIZE_WORD);
   assign hit     = word_wr && (mem_addr == TOHOST_ADDR);
   assign con_hit = word_wr && (state_q == RUN) &&
                    (mem_addr == TOHOST_ADDR + ADDR_W'(CONSOLE_OFFSET));

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cnt_d     = cnt_q;
      fc_d      = fc_q;
      case (state_q)
         HOLD: begin
            rst_cnt_d = rst_cnt_q - 1'b1;
            if (rst_cnt_q <= RW'(1)) state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            // Odd stores are verdicts; even stores are ignored so timeout can still fire.
            if (hit && mem_data[0]) begin
               if (mem_data == DATA_W'(1)) begin
                  state_d = PASS;
               end else begin
                  state_d = FAIL;
                  fc_d    = mem_data >> 1;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = TMO;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= HOLD;
         rst_cnt_q <= RW'(RST_CYCLES);
         cnt_q     <= '0;
         fc_q      <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cnt_q     <= cnt_d;
         fc_q      <= fc_d;
      end
   end

   assign cpu_reset   = (state_q == HOLD);
   assign cycle_count = cnt_q;
   assign done        = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
   assign pass        = (state_q == PASS);
   assign timed_out   = (state_q == TMO);
   assign fail_code   = fc_q;

`ifdef CPU_RUN_MONITOR_CONSOLE_EN
   cpu_run_console_fifo #(
      .DEPTH_LOG2 (CON_DEPTH_LOG2)
   ) u_console (
      .clk        (clk),
      .rst        (reset),
      .push_i     (con_hit),
      .data_i     (mem_data[7:0]),
      .ready_i    (con_ready),
      .data_o     (con_data),
      .valid_o    (con_valid),
      .overflow_o (con_overflow)
   );
`else
   logic unused_con;
   assign unused_con   = &{1'b0, con_ready, con_hit};
   assign con_data     = 8'h00;
   assign con_valid    = 1'b0;
   assign con_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two instances (long and short timeout) share
// stimulus and are checked against an edge-log reference model.
module tb_cpu_run_monitor;

   localparam int RST   = 4;
   localparam int TMO_A = 100;
   localparam int TMO_B = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_data = '0;
   logic [2:0]  mem_size = '0;
   logic        con_ready = 1'b0;

   logic        a_cpu_reset, a_done, a_pass, a_timed_out, a_con_valid, a_con_overflow;
   logic [31:0] a_cycle_count, a_fail_code;
   logic [7:0]  a_con_data;
   logic        b_cpu_reset, b_done, b_pass, b_timed_out, b_con_valid, b_con_overflow;
   logic [31:0] b_cycle_count, b_fail_code;
   logic [7:0]  b_con_data;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   cpu_run_monitor #(.RST_CYCLES(RST), .TIMEOUT(TMO_A)) u_a (
      .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_size(mem_size), .cpu_reset(a_cpu_reset),
      .cycle_count(a_cycle_count), .done(a_done), .pass(a_pass),
      .timed_out(a_timed_out), .fail_code(a_fail_code), .con_data(a_con_data),
      .con_valid(a_con_valid), .con_ready(con_ready), .con_overflow(a_con_overflow));

   cpu_run_monitor #(.RST_CYCLES(RST), .TIMEOUT(TMO_B)) u_b (
      .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_size(mem_size), .cpu_reset(b_cpu_reset),
      .cycle_count(b_cycle_count), .done(b_done), .pass(b_pass),
      .timed_out(b_timed_out), .fail_code(b_fail_code), .con_data(b_con_data),
      .con_valid(b_con_valid), .con_ready(con_ready), .con_overflow(b_con_overflow));

   // Reference model: every rising edge since reset release is logged; the
   // expected outputs are derived from that history.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
   } ev_t;
   ev_t log_q[$];

   always @(posedge clk) begin
      if (!reset) log_q.push_back('{we: mem_we, addr: mem_addr, size: mem_size, data: mem_data});
   end

   function automatic logic [67:0] expv(input int tmo);
      logic        crst, dn, ps, to;
      logic [31:0] cnt, fc;
      dn = 0; ps = 0; to = 0; cnt = 0; fc = 0;
      crst = (log_q.size() < RST);
      for (int k = 0; k < log_q.size(); k++) begin
         if (k < RST || dn) continue;
         cnt = k - RST + 1;
         if (log_q[k].we && log_q[k].addr == 32'h1000 && log_q[k].size == 3'd2 && log_q[k].data[0]) begin
            dn = 1;
            if (log_q[k].data == 1) ps = 1;
            else fc = log_q[k].data / 2;
         end else if (k - RST == tmo - 1) begin
            dn = 1;
            to = 1;
         end
      end
      return {crst, dn, ps, to, cnt, fc};
   endfunction

   logic [67:0] obs_a, obs_b;
   assign obs_a = {a_cpu_reset, a_done, a_pass, a_timed_out, a_cycle_count, a_fail_code};
   assign obs_b = {b_cpu_reset, b_done, b_pass, b_timed_out, b_cycle_count, b_fail_code};

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      log_q.delete();
      mem_we = 0; mem_addr = 0; mem_data = 0; mem_size = 0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one write for exactly one edge; returns on the following negedge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
      mem_we = 1; mem_addr = addr; mem_data = data; mem_size = size;
      @(negedge clk);
      mem_we = 0; mem_addr = 0; mem_data = 0; mem_size = 0;
   endtask

   task automatic test_reset;
      step(3);
      nchk++;
      if (obs_a !== {1'b1, 3'b000, 64'h0} || a_con_valid !== 0 || a_con_data !== 0 || a_con_overflow !== 0) begin
         nfail++; $display("FAIL reset_vals: got %h want %h", obs_a, {1'b1, 3'b000, 64'h0});
      end
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         nchk++;
         if (a_cpu_reset !== (i < RST)) begin
            nfail++; $display("FAIL cpu_reset_edge%0d: got %b want %b", i, a_cpu_reset, (i < RST));
         end
         nchk++;
         if (obs_b !== expv(TMO_B)) begin
            nfail++; $display("FAIL reset_model_b%0d: got %h want %h", i, obs_b, expv(TMO_B));
         end
         if (i == RST) begin
            nchk++;
            if (a_cycle_count !== 0) begin
               nfail++; $display("FAIL count_at_release: got %0d want 0", a_cycle_count);
            end
         end
      end
   endtask

   task automatic test_pass;
      do_reset(2);
      step(RST + 49);
      wr(32'h1000, 32'd1, 3'd2);
      nchk++;
      if ({a_done, a_pass, a_timed_out, a_fail_code, a_cycle_count} !== {3'b110, 32'd0, 32'd50}) begin
         nfail++; $display("FAIL pass_verdict: got %b%b%b fc=%0d cnt=%0d want 110 fc=0 cnt=50",
                           a_done, a_pass, a_timed_out, a_fail_code, a_cycle_count);
      end
      step(5);
      nchk++;
      if (obs_a !== expv(TMO_A) || a_cycle_count !== 50) begin
         nfail++; $display("FAIL pass_frozen: got %h want %h", obs_a, expv(TMO_A));
      end
      nchk++;
      if (obs_b !== expv(TMO_B)) begin
         nfail++; $display("FAIL pass_model_b: got %h want %h", obs_b, expv(TMO_B));
      end
   endtask

   task automatic test_fail;
      do_reset(1);
      step(RST + 5);
      wr(32'h1000, 32'd7, 3'd2);
      nchk++;
      if ({a_done, a_pass, a_fail_code} !== {2'b10, 32'd3}) begin
         nfail++; $display("FAIL fail_verdict: got done=%b pass=%b fc=%0d want 1 0 3", a_done, a_pass, a_fail_code);
      end
      step(3);
      wr(32'h1000, 32'd1, 3'd2);
      step(2);
      nchk++;
      if ({a_done, a_pass, a_fail_code, a_cycle_count} !== {2'b10, 32'd3, 32'd6}) begin
         nfail++; $display("FAIL fail_sticky: got done=%b pass=%b fc=%0d cnt=%0d want 1 0 3 6",
                           a_done, a_pass, a_fail_code, a_cycle_count);
      end
      nchk++;
      if (obs_b !== expv(TMO_B)) begin
         nfail++; $display("FAIL fail_model_b: got %h want %h", obs_b, expv(TMO_B));
      end
   endtask

   task automatic test_timeout;
      do_reset(2);
      step(RST + 25);
      nchk++;
      if ({b_done, b_pass, b_timed_out, b_cycle_count} !== {3'b101, 32'd20}) begin
         nfail++; $display("FAIL timeout: got %b%b%b cnt=%0d want 101 cnt=20", b_done, b_pass, b_timed_out, b_cycle_count);
      end
      nchk++;
      if (obs_a !== expv(TMO_A)) begin
         nfail++; $display("FAIL timeout_model_a: got %h want %h", obs_a, expv(TMO_A));
      end
      // Pass store on the very edge the timeout would fire.
      do_reset(2);
      step(RST + 19);
      wr(32'h1000, 32'd1, 3'd2);
      nchk++;
      if ({b_done, b_pass, b_timed_out, b_cycle_count} !== {3'b110, 32'd20}) begin
         nfail++; $display("FAIL timeout_vs_pass: got %b%b%b cnt=%0d want 110 cnt=20", b_done, b_pass, b_timed_out, b_cycle_count);
      end
      // Even store on the timeout edge does not block it.
      do_reset(2);
      step(RST + 19);
      wr(32'h1000, 32'd4, 3'd2);
      nchk++;
      if ({b_done, b_pass, b_timed_out} !== 3'b101) begin
         nfail++; $display("FAIL timeout_even_store: got %b%b%b want 101", b_done, b_pass, b_timed_out);
      end
   endtask

   task automatic test_ignored;
      do_reset(2);
      step(RST + 8);
      wr(32'h1000, 32'd1, 3'd0);
      wr(32'h1000, 32'd0, 3'd2);
      wr(32'h1008, 32'd1, 3'd2);
      wr(32'h1004, 32'd1, 3'd2);
      wr(32'h1000, 32'd3, 3'd1);
      step(1);
      nchk++;
      if (a_done !== 0 || b_done !== 0 || a_cycle_count !== 14) begin
         nfail++; $display("FAIL ignored_writes: got done=%b/%b cnt=%0d want 0/0 cnt=14", a_done, b_done, a_cycle_count);
      end
      nchk++;
      if (obs_a !== expv(TMO_A)) begin
         nfail++; $display("FAIL ignored_model_a: got %h want %h", obs_a, expv(TMO_A));
      end
      #2 reset = 1'b1;
      log_q.delete();
      #1;
      nchk++;
      if (obs_a !== {1'b1, 3'b000, 64'h0} || a_con_valid !== 0 || a_con_data !== 0 || a_con_overflow !== 0) begin
         nfail++; $display("FAIL midrun_reset: got %h want %h", obs_a, {1'b1, 3'b000, 64'h0});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_console;
      logic [7:0] ch;
      do_reset(2);
      step(RST + 2);
      con_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ch = 8'h41 + 8'(i);
         wr(32'h1004, {24'h0, ch}, 3'd2);
      end
`ifdef CPU_RUN_MONITOR_CONSOLE_EN
      nchk++;
      if ({a_con_valid, a_con_data, a_con_overflow} !== {1'b1, 8'h41, 1'b1}) begin
         nfail++; $display("FAIL console_full: got v=%b d=%h o=%b want 1 41 1", a_con_valid, a_con_data, a_con_overflow);
      end
      con_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         ch = 8'h41 + 8'(j);
         nchk++;
         if (a_con_valid !== 1 || a_con_data !== ch) begin
            nfail++; $display("FAIL console_pop%0d: got v=%b d=%h want 1 %h", j, a_con_valid, a_con_data, ch);
         end
         @(negedge clk);
      end
      nchk++;
      if (a_con_valid !== 0 || a_con_overflow !== 1) begin
         nfail++; $display("FAIL console_drained: got v=%b o=%b want 0 1", a_con_valid, a_con_overflow);
      end
`else
      nchk++;
      if ({a_con_valid, a_con_data, a_con_overflow} !== 10'h0) begin
         nfail++; $display("FAIL console_off: got v=%b d=%h o=%b want 0 00 0", a_con_valid, a_con_data, a_con_overflow);
      end
`endif
      nchk++;
      if (obs_a !== expv(TMO_A)) begin
         nfail++; $display("FAIL console_no_verdict: got %h want %h", obs_a, expv(TMO_A));
      end
      con_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [31:0] addrs [4];
      logic [2:0]  sizes [4];
      addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h0FFC; addrs[3] = 32'h1000;
      sizes[0] = 3'd2; sizes[1] = 3'd2; sizes[2] = 3'd0; sizes[3] = 3'd1;
      for (int run = 0; run < 6; run++) begin
         do_reset($urandom_range(1, 3));
         for (int c = 0; c < 130; c++) begin
            nchk++;
            if (obs_a !== expv(TMO_A)) begin
               nfail++; $display("FAIL rand_a run%0d cyc%0d: got %h want %h", run, c, obs_a, expv(TMO_A));
            end
            nchk++;
            if (obs_b !== expv(TMO_B)) begin
               nfail++; $display("FAIL rand_b run%0d cyc%0d: got %h want %h", run, c, obs_b, expv(TMO_B));
            end
            con_ready = 1'($urandom);
            mem_we    = ($urandom_range(0, 11) == 0);
            mem_addr  = addrs[$urandom_range(0, 3)];
            mem_size  = sizes[$urandom_range(0, 3)];
            mem_data  = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'($urandom_range(0, 15));
            @(negedge clk);
         end
         mem_we = 0;
      end
   endtask

   initial begin
      test_reset;
      test_pass;
      test_fail;
      test_timeout;
      test_ignored;
      test_console;
      test_random;
      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and result monitor for CPU simulation and FPGA bring-up. It wraps the CPU core, sequences the core's reset and watches data-memory write traffic for a "tohost" store. It also counts cycles and enforces a timeout. It ends the run with a registered pass/fail/timeout verdict that benches and on-board LEDs read directly, in place of free-running hand-written clock/reset loops.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data-memory write-data width
- CNT_W, 32, cycle counter width
- RST_CYCLES, 4, extra clk cycles `cpu_reset` is held after `reset` deasserts (≥1)
- TIMEOUT, 100000, run-cycle limit before the timeout verdict (< 2^CNT_W)
- TOHOST_ADDR, 32'h0000_1000, verdict mailbox address
- CON_DEPTH_LOG2, 2, console FIFO depth = 2^CON_DEPTH_LOG2 (console feature only)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  one clock; asynchronous, active-high reset
- mem_we  in  1  CPU data-memory write enable
- mem_addr  in  ADDR_W  CPU data-memory address
- mem_data  in  DATA_W  CPU data-memory write data
- mem_size  in  3  CPU access size; 3'b010 = word
- cpu_reset  out  1  reset to the CPU core
- cycle_count  out  CNT_W  cycles spent in RUN
- done  out  1  verdict reached (sticky)
- pass  out  1  verdict is pass (valid with done)
- timed_out  out  1  verdict is timeout (valid with done)
- fail_code  out  DATA_W  test number of the failing test, mem_data>>1
- con_data  out  8  console character
- con_valid  out  1  console character available
- con_ready  in  1  consumer accepts con_data
- con_overflow  out  1  sticky: a console character was dropped

## Operation
- FSM states: HOLD, RUN, PASS, FAIL, TMO.
- HOLD: cpu_reset=1; an RST_CYCLES down-counter loads on reset and decrements each clk; at 0 → RUN.
- RUN: cpu_reset=0; cycle_count increments every clk.
- Mailbox hit: mem_we=1, mem_addr==TOHOST_ADDR and mem_size==3'b010, sampled at a rising edge in RUN.
  - Hit with mem_data[0]=1 and mem_data==1 → PASS.
  - Hit with mem_data[0]=1 and any other value → FAIL, fail_code ← mem_data>>1.
  - Hit with mem_data[0]=0 → ignored.
- Timeout: in RUN, when cycle_count==TIMEOUT-1 and no mailbox hit on that edge → TMO. A mailbox hit on the same edge takes priority over timeout.
- PASS/FAIL/TMO are terminal until reset: counters freeze, writes are ignored, cpu_reset stays 0 and the core keeps running.
- Outputs decode from state: done = PASS|FAIL|TMO; pass = PASS; timed_out = TMO.
- Non-word accesses to TOHOST_ADDR are ignored.

## Timing
- Reset values: cpu_reset=1, cycle_count=0, done=0, pass=0, timed_out=0, fail_code=0, con_valid=0, con_data=0, con_overflow=0, state HOLD.
- cpu_reset rises asynchronously with reset. It falls exactly RST_CYCLES rising edges after the first edge with reset low.
- Verdict latency: done/pass/fail_code are valid the cycle after the edge that sampled the mailbox store (1 cycle, registered).
- cycle_count shows N after N RUN edges. It freezes at TIMEOUT on a timeout.
- reset asserted mid-run (any state) clears everything immediately and restarts from HOLD; the console FIFO is flushed.

## Configuration
- CPU_RUN_MONITOR_CONSOLE_EN defined:
  - Word writes to TOHOST_ADDR+4 in RUN push mem_data[7:0] into a 2^CON_DEPTH_LOG2-entry FIFO.
  - The FIFO uses a valid/ready output: a pop occurs on an edge with con_valid&con_ready.
  - A push when full drops the character and sets con_overflow. Push and pop on the same edge while full succeed together with no overflow.
  - Console traffic never affects the verdict.
- Macro undefined: no FIFO; con_valid=0, con_data=0, con_overflow=0 constant; con_ready unused.

## Structure
- Package cpu_run_monitor_pkg holds the state enum (HOLD, RUN, PASS, FAIL, TMO), the MEM_SIZE_WORD=3'b010 constant and the CONSOLE_OFFSET=4 constant.
- One sub-module, cpu_run_console_fifo: 8-bit sync FIFO with wrap-around pointers plus an extra bit for full/empty. It is instantiated only under the macro.

## Test plan
- Reset held 3 cycles, then released, RST_CYCLES=4 → cpu_reset falls on the 4th edge after release; cycle_count=0 at that point.
- Word write 1 to 0x1000 after 50 RUN cycles → next cycle done=1, pass=1, fail_code=0; cycle_count frozen at 50.
- Word write 7 to 0x1000 → done=1, pass=0, fail_code=3. A later write of 1 does not change the verdict.
- TIMEOUT=20 and no mailbox write → timed_out=1, done=1, cycle_count=20. In a second run, a pass write on the edge where cycle_count==19 → pass=1, timed_out=0.
- Byte write (mem_size=0) of 1 to 0x1000, then a word write of 0 → no verdict. reset pulse mid-RUN → all outputs return to their reset values and cpu_reset=1.
- (CONSOLE_EN, depth 4) with con_ready=0, write 'A'..'E' to 0x1004 → con_valid=1, con_data='A', con_overflow=1. Raise con_ready → A, B, C, D are popped in order, then con_valid=0.
